// File: rtl/onewire_txn_ctrl.sv
// onewire_txn_ctrl: sequences one 1-wire transaction (reset, 16 write slots, N x 8 read slots)
// on the bit-slot engine. Define ONEWIRE_TXN_CRC_EN to build the CRC-8 check over read data.
module onewire_txn_ctrl #(
  parameter int SLOT_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] rom_cmd,
  input  logic [7:0] fn_cmd,
  input  logic [3:0] rd_len,
  output logic       busy,
  output logic       done,
  output logic       err_nopres,
  output logic       err_timeout,
  output logic       err_crc,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       slot_start,
  output logic [1:0] slot_type,
  input  logic       slot_done,
  input  logic       slot_bit
);

  typedef enum logic [2:0] {
    IDLE, RST_ISSUE, RST_WAIT, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, FINISH
  } state_t;

  // Counter starts at 0 in the first wait cycle, so this value puts done exactly
  // SLOT_TIMEOUT cycles after slot_start.
  localparam logic [9:0] TO_LAST = 10'(SLOT_TIMEOUT - 2);

  state_t     state_q, state_d;
  logic [7:0] rom_q, rom_d, fn_q, fn_d, shift_q, shift_d, rd_data_q, rd_data_d;
  logic [3:0] len_q, len_d, rd_cnt_q, rd_cnt_d;
  logic [2:0] bit_q, bit_d;
  logic       sel_q, sel_d;
  logic [9:0] to_q, to_d;
  logic       rd_valid_q, rd_valid_d, nopres_q, nopres_d, tout_q, tout_d;
  logic       accept_s, to_hit_s, wr_bit_s;
`ifdef ONEWIRE_TXN_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       crcerr_q, crcerr_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    crc8_step = (crc >> 1) ^ (((crc[0] ^ b) == 1'b1) ? 8'h8C : 8'h00);
  endfunction
`endif

  assign accept_s = req && (state_q == IDLE || state_q == FINISH);
  assign to_hit_s = (to_q == TO_LAST);
  assign wr_bit_s = sel_q ? fn_q[bit_q] : rom_q[bit_q];

  always_comb begin
    state_d    = state_q;
    rom_d      = rom_q;
    fn_d       = fn_q;
    len_d      = len_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;
    rd_cnt_d   = rd_cnt_q;
    bit_d      = bit_q;
    sel_d      = sel_q;
    to_d       = to_q;
    rd_valid_d = 1'b0;
    nopres_d   = nopres_q;
    tout_d     = tout_q;
`ifdef ONEWIRE_TXN_CRC_EN
    crc_d      = crc_q;
    crcerr_d   = crcerr_q;
`endif
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (accept_s) begin
          state_d  = RST_ISSUE;
          rom_d    = rom_cmd;
          fn_d     = fn_cmd;
          len_d    = rd_len;
          rd_cnt_d = 4'd0;
          bit_d    = 3'd0;
          sel_d    = 1'b0;
          nopres_d = 1'b0;
          tout_d   = 1'b0;
`ifdef ONEWIRE_TXN_CRC_EN
          crc_d    = 8'h00;
          crcerr_d = 1'b0;
`endif
        end
      end
      RST_ISSUE, WR_ISSUE, RD_ISSUE: begin
        to_d = 10'd0;
        if (state_q == RST_ISSUE)     state_d = RST_WAIT;
        else if (state_q == WR_ISSUE) state_d = WR_WAIT;
        else                          state_d = RD_WAIT;
      end
      RST_WAIT, WR_WAIT, RD_WAIT: begin
        to_d = to_q + 10'd1;
        if (slot_done) begin
          if (state_q == RST_WAIT) begin
            if (slot_bit) begin
              nopres_d = 1'b1;
              state_d  = FINISH;
            end else begin
              state_d  = WR_ISSUE;
            end
          end else if (state_q == WR_WAIT) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) sel_d = ~sel_q;
            if (bit_q == 3'd7 && sel_q) state_d = (len_q == 4'd0) ? FINISH : RD_ISSUE;
            else                        state_d = WR_ISSUE;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {slot_bit, shift_q[7:1]};
            state_d = RD_ISSUE;
`ifdef ONEWIRE_TXN_CRC_EN
            crc_d   = crc8_step(crc_q, slot_bit);
`endif
            if (bit_q == 3'd7) begin
              rd_data_d  = {slot_bit, shift_q[7:1]};
              rd_valid_d = 1'b1;
              rd_cnt_d   = rd_cnt_q + 4'd1;
              if ((rd_cnt_q + 4'd1) == len_q) begin
                state_d = FINISH;
`ifdef ONEWIRE_TXN_CRC_EN
                // The last byte read is the CRC byte, so a clean stream leaves zero.
                crcerr_d = (crc8_step(crc_q, slot_bit) != 8'h00);
`endif
              end
            end
          end
        end else if (to_hit_s) begin
          tout_d  = 1'b1;
          state_d = FINISH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rom_q      <= 8'h00;
      fn_q       <= 8'h00;
      len_q      <= 4'd0;
      shift_q    <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_cnt_q   <= 4'd0;
      bit_q      <= 3'd0;
      sel_q      <= 1'b0;
      to_q       <= 10'd0;
      rd_valid_q <= 1'b0;
      nopres_q   <= 1'b0;
      tout_q     <= 1'b0;
`ifdef ONEWIRE_TXN_CRC_EN
      crc_q      <= 8'h00;
      crcerr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rom_q      <= rom_d;
      fn_q       <= fn_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      rd_cnt_q   <= rd_cnt_d;
      bit_q      <= bit_d;
      sel_q      <= sel_d;
      to_q       <= to_d;
      rd_valid_q <= rd_valid_d;
      nopres_q   <= nopres_d;
      tout_q     <= tout_d;
`ifdef ONEWIRE_TXN_CRC_EN
      crc_q      <= crc_d;
      crcerr_q   <= crcerr_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE) && (state_q != FINISH);
  assign done        = (state_q == FINISH);
  assign slot_start  = (state_q == RST_ISSUE) || (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign err_nopres  = nopres_q;
  assign err_timeout = tout_q;
`ifdef ONEWIRE_TXN_CRC_EN
  assign err_crc     = crcerr_q;
`else
  assign err_crc     = 1'b0;
`endif

  always_comb begin
    slot_type = 2'b00;
    case (state_q)
      WR_ISSUE: slot_type = wr_bit_s ? 2'b10 : 2'b01;
      RD_ISSUE: slot_type = 2'b11;
      default:  slot_type = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_onewire_txn_ctrl.sv
// Directed bench for onewire_txn_ctrl: acts as the bit engine and checks slot sequence,
// read data, error flags and timing.
module tb_onewire_txn_ctrl;
  logic       clk = 1'b0;
  logic       reset, req, slot_done, slot_bit;
  logic [7:0] rom_cmd, fn_cmd;
  logic [3:0] rd_len;
  logic       busy, done, err_nopres, err_timeout, err_crc, rd_valid, slot_start;
  logic [7:0] rd_data;
  logic [1:0] slot_type;
  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  logic [7:0] pad [0:8];
  logic       crc_bad_exp;

  onewire_txn_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .rom_cmd(rom_cmd), .fn_cmd(fn_cmd), .rd_len(rd_len),
    .busy(busy), .done(done), .err_nopres(err_nopres), .err_timeout(err_timeout),
    .err_crc(err_crc), .rd_data(rd_data), .rd_valid(rd_valid), .slot_start(slot_start),
    .slot_type(slot_type), .slot_done(slot_done), .slot_bit(slot_bit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for slot_start (expected immediately), check its type, answer after lat cycles.
  task automatic do_slot(input logic [1:0] ty, input logic b, input int lat, input string tag);
    int n = 0;
    while (slot_start !== 1'b1 && n < 50) begin tick(); n++; end
    chk(32'(n), 32'd0, {tag, " turnaround"});
    chk(32'(slot_type), 32'(ty), {tag, " slot_type"});
    repeat (lat + 1) tick();
    slot_done = 1'b1; slot_bit = b;
    tick();
    slot_done = 1'b0; slot_bit = 1'b1;
  endtask

  task automatic start(input logic [7:0] rc, input logic [7:0] fc, input logic [3:0] len);
    rom_cmd = rc; fn_cmd = fc; rd_len = len; req = 1'b1;
    tick();
    req = 1'b0;
    chk(32'(busy), 32'd1, "busy after accept");
  endtask

  task automatic writes(input logic [7:0] rc, input logic [7:0] fc, input int nwr);
    logic b;
    for (int i = 0; i < nwr; i++) begin
      b = (i < 8) ? rc[i] : fc[i - 8];
      do_slot(b ? 2'b10 : 2'b01, b, i % 3, "write");
    end
  endtask

  task automatic reads(input int nbytes);
    for (int j = 0; j < nbytes; j++) begin
      for (int i = 0; i < 8; i++) do_slot(2'b11, pad[j][i], (i + j) % 2, "read");
      chk(32'(rd_valid), 32'd1, "rd_valid");
      chk(32'(rd_data), 32'(pad[j]), "rd_data");
      chk(32'(done), (j == nbytes - 1) ? 32'd1 : 32'd0, "done with last byte");
    end
  endtask

  initial begin
    int cnt;
    int s;
    reset = 1'b1; req = 1'b0; slot_done = 1'b0; slot_bit = 1'b1;
    rom_cmd = 8'h00; fn_cmd = 8'h00; rd_len = 4'd0;
    repeat (3) tick();
    reset = 1'b0;
    chk({busy, done, slot_start, rd_valid, err_nopres, err_timeout, err_crc}, 32'd0, "reset outputs");
    chk(32'(rd_data), 32'd0, "reset rd_data");

    // Skip ROM + convert, no read bytes.
    start(8'hCC, 8'h44, 4'd0);
    chk(32'(slot_start), 32'd1, "cycle1 slot_start");
    do_slot(2'b00, 1'b0, 2, "presence");
    writes(8'hCC, 8'h44, 16);
    chk(32'(done), 32'd1, "t1 done");
    chk(32'(busy), 32'd0, "t1 busy");
    chk({err_nopres, err_timeout, err_crc}, 32'd0, "t1 errors");
    tick();
    chk(32'(done), 32'd0, "t1 done one cycle");

    // No slave answers the reset slot.
    start(8'hCC, 8'h44, 4'd0);
    do_slot(2'b00, 1'b1, 0, "nopres slot");
    chk(32'(done), 32'd1, "nopres done");
    chk(32'(err_nopres), 32'd1, "err_nopres");
    chk(32'(busy), 32'd0, "nopres busy");
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (slot_start === 1'b1) cnt++; end
    chk(32'(cnt), 32'd0, "no write slots after nopres");

    // Scratchpad read; req and operands disturbed while busy.
    pad[0] = 8'h50; pad[1] = 8'h05; pad[2] = 8'h4B; pad[3] = 8'h46; pad[4] = 8'h7F;
    pad[5] = 8'hFF; pad[6] = 8'h0C; pad[7] = 8'h10; pad[8] = 8'h1C;
    rom_cmd = 8'hCC; fn_cmd = 8'hBE; rd_len = 4'd9; req = 1'b1;
    tick();
    rom_cmd = 8'h00; fn_cmd = 8'hFF; rd_len = 4'd1;
    do_slot(2'b00, 1'b0, 1, "presence busy-req");
    req = 1'b0;
    chk(32'(err_nopres), 32'd0, "err_nopres cleared on accept");
    writes(8'hCC, 8'hBE, 16);
    reads(9);
    chk(32'(err_crc), 32'd0, "good scratchpad crc");
    chk(32'(busy), 32'd0, "read busy");

    // Same read with a corrupted byte.
    pad[2] = 8'h4A;
`ifdef ONEWIRE_TXN_CRC_EN
    crc_bad_exp = 1'b1;
`else
    crc_bad_exp = 1'b0;
`endif
    start(8'hCC, 8'hBE, 4'd9);
    do_slot(2'b00, 1'b0, 0, "presence");
    writes(8'hCC, 8'hBE, 16);
    reads(9);
    chk(32'(err_crc), 32'(crc_bad_exp), "corrupt scratchpad crc");

    // Engine never finishes fn_cmd bit 5.
    start(8'hCC, 8'h44, 4'd0);
    do_slot(2'b00, 1'b0, 0, "presence");
    writes(8'hCC, 8'h44, 13);
    chk(32'(slot_start), 32'd1, "timeout slot_start");
    chk(32'(slot_type), 32'h1, "timeout slot_type");
    s = cyc;
    cnt = 0;
    while (done !== 1'b1 && cnt < 1100) begin tick(); cnt++; end
    chk(32'(cyc - s), 32'd1023, "timeout latency");
    chk(32'(err_timeout), 32'd1, "err_timeout");
    chk(32'(err_nopres), 32'd0, "timeout nopres");

    // Reset in the middle of the read phase.
    pad[2] = 8'h4B;
    start(8'hCC, 8'hBE, 4'd2);
    do_slot(2'b00, 1'b0, 0, "presence");
    writes(8'hCC, 8'hBE, 16);
    for (int i = 0; i < 3; i++) do_slot(2'b11, 1'b1, 0, "read pre-reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk({busy, done, slot_start, rd_valid, err_nopres, err_timeout, err_crc}, 32'd0, "midreset outputs");
    chk(32'(rd_data), 32'd0, "midreset rd_data");
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || rd_valid === 1'b1 || slot_start === 1'b1) cnt++;
      slot_done = (i == 3); slot_bit = 1'b1;
      tick();
    end
    slot_done = 1'b0;
    chk(32'(cnt), 32'd0, "quiet after reset");
    start(8'hCC, 8'h44, 4'd0);
    do_slot(2'b00, 1'b0, 1, "post-reset presence");
    writes(8'hCC, 8'h44, 16);
    chk(32'(done), 32'd1, "post-reset done");
    chk({err_nopres, err_timeout, err_crc}, 32'd0, "post-reset errors");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
